irrigation_zone_scheduler: RTL and testbench

Multi-zone successor to the single-bed irrigation controller. It sequences watering across `ZONES` beds from one shared tank, choosing sprinkler or dripper per zone and timing each run with an internal seconds countdown. It also keeps the existing water-sensor fault, alarm and refill-valve behaviour. It sits between the sensor inputs and the valve/pump drivers. `active_zone` and `remaining_seconds` feed the display path.

---
 rtl/irrigation_zone_scheduler_if.sv | 41 ++++
 rtl/irrigation_zone_scheduler.sv | 172 +++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_zone_scheduler_if.sv
// Sensor / valve bundle for irrigation_zone_scheduler.
//   master : sensor side, drives probes, weather flags, zone_dry and skip,
//            and observes the valve/display/status outputs.
//   slave  : the scheduler, which consumes the sensors and drives the
//            pump, valve, display and status outputs.
interface irrigation_zone_scheduler_if #(
  parameter int unsigned ZONES      = 4,
  parameter int unsigned TIME_WIDTH = 8
);
  localparam int unsigned ZW = $clog2(ZONES);

  logic                  low_water_level;
  logic                  mid_water_level;
  logic                  high_water_level;
  logic                  air_humidity;
  logic                  low_temperature;
  logic [ZONES-1:0]      zone_dry;
  logic                  skip;

  logic [ZONES-1:0]      splinker_bomb;
  logic [ZONES-1:0]      dripper_valvule;
  logic [ZW-1:0]         active_zone;
  logic [TIME_WIDTH-1:0] remaining_seconds;
  logic                  conflicting_values;
  logic                  alarm;
  logic                  water_supply_valvule;

  modport master (
    output low_water_level, mid_water_level, high_water_level,
           air_humidity, low_temperature, zone_dry, skip,
    input  splinker_bomb, dripper_valvule, active_zone, remaining_seconds,
           conflicting_values, alarm, water_supply_valvule
  );

  modport slave (
    input  low_water_level, mid_water_level, high_water_level,
           air_humidity, low_temperature, zone_dry, skip,
    output splinker_bomb, dripper_valvule, active_zone, remaining_seconds,
           conflicting_values, alarm, water_supply_valvule
  );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler sharing one tank.
// Registers all sensor inputs once, flags inconsistent tank-probe patterns,
// drives the refill valve and alarm, and waters dry beds one at a time in
// round-robin order, choosing sprinkler or dripper per run and timing each
// run with a seconds countdown derived from a clock prescaler.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : irrigation_zone_scheduler_if.slave
//            in : low/mid/high_water_level, air_humidity, low_temperature,
//                 zone_dry[ZONES], skip
//            out: splinker_bomb[ZONES], dripper_valvule[ZONES] (one valve max),
//                 active_zone, remaining_seconds, conflicting_values, alarm,
//                 water_supply_valvule
module irrigation_zone_scheduler #(
  parameter int unsigned ZONES             = 4,
  parameter int unsigned TICK_DIV          = 50_000_000,
  parameter int unsigned TIME_WIDTH        = 8,
  parameter int unsigned SPRINKLER_SECONDS = 120,
  parameter int unsigned DRIPPER_SECONDS   = 240
) (
  input  logic                         clock,
  input  logic                         reset,
  irrigation_zone_scheduler_if.slave   bus
);
  localparam int unsigned ZW = $clog2(ZONES);
  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WATER, S_FAULT} state_t;

  // registered sensor copies
  logic             low_q, mid_q, high_q, air_q, cold_q, skip_q;
  logic [ZONES-1:0] dry_q;

  logic [CW-1:0]         presc_q, presc_d;
  logic                  tick;
  state_t                state_q, state_d;
  logic [ZW-1:0]         zone_q, zone_d;
  logic [ZW-1:0]         ptr_q, ptr_d;
  logic [TIME_WIDTH-1:0] cnt_q, cnt_d;
  logic                  spr_q, spr_d;

  logic          conflict;
  logic          sprinkler_mode;
  logic          sel_found;
  logic [ZW-1:0] sel_zone;
  logic [ZW-1:0] zone_after;

  always_ff @(posedge clock) begin
    if (reset) begin
      low_q   <= 1'b0;
      mid_q   <= 1'b0;
      high_q  <= 1'b0;
      air_q   <= 1'b0;
      cold_q  <= 1'b0;
      skip_q  <= 1'b0;
      dry_q   <= '0;
      presc_q <= '0;
      state_q <= S_IDLE;
      zone_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      spr_q   <= 1'b0;
    end else begin
      low_q   <= bus.low_water_level;
      mid_q   <= bus.mid_water_level;
      high_q  <= bus.high_water_level;
      air_q   <= bus.air_humidity;
      cold_q  <= bus.low_temperature;
      skip_q  <= bus.skip;
      dry_q   <= bus.zone_dry;
      presc_q <= presc_d;
      state_q <= state_d;
      zone_q  <= zone_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      spr_q   <= spr_d;
    end
  end

  // Probes fill bottom-up, so only 000/001/011/111 are physically possible.
  always_comb begin
    case ({high_q, mid_q, low_q})
      3'b000, 3'b001, 3'b011, 3'b111: conflict = 1'b0;
      default:                        conflict = 1'b1;
    endcase
  end

  always_comb begin
    tick    = (presc_q == CW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  assign sprinkler_mode = !air_q && !cold_q && mid_q;
  assign zone_after     = (zone_q == ZW'(ZONES - 1)) ? '0 : zone_q + 1'b1;

  // First dry zone at or after ptr_q, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_zone  = ptr_q;
    for (int unsigned i = 0; i < ZONES; i++) begin
      int unsigned   idx;
      logic [ZW-1:0] cand;
      idx = 32'(ptr_q) + i;
      if (idx >= ZONES) idx = idx - ZONES;
      cand = ZW'(idx);
      if (!sel_found && dry_q[cand]) begin
        sel_found = 1'b1;
        sel_zone  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    spr_d   = spr_q;
    if (conflict) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (low_q && (|dry_q)) state_d = S_SELECT;
        end
        S_SELECT: begin
          // The request may have vanished since IDLE saw it.
          if (sel_found) begin
            state_d = S_WATER;
            zone_d  = sel_zone;
            spr_d   = sprinkler_mode;
            cnt_d   = sprinkler_mode ? TIME_WIDTH'(SPRINKLER_SECONDS)
                                     : TIME_WIDTH'(DRIPPER_SECONDS);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WATER: begin
          if (!low_q || skip_q || !dry_q[zone_q]) begin
            state_d = S_IDLE;
            ptr_d   = zone_after;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == TIME_WIDTH'(1)) begin
              state_d = S_IDLE;
              ptr_d   = zone_after;
            end
          end
        end
        S_FAULT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.splinker_bomb   = '0;
    bus.dripper_valvule = '0;
    if (state_q == S_WATER) begin
      if (spr_q) bus.splinker_bomb[zone_q]   = 1'b1;
      else       bus.dripper_valvule[zone_q] = 1'b1;
    end
  end

  assign bus.active_zone          = zone_q;
  assign bus.remaining_seconds    = cnt_q;
  assign bus.conflicting_values   = conflict;
  assign bus.alarm                = conflict | ~mid_q;
  assign bus.water_supply_valvule = ~conflict & ~high_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler with ZONES=4, TICK_DIV=4,
// SPRINKLER_SECONDS=3, DRIPPER_SECONDS=5.
module tb_irrigation_zone_scheduler;
  localparam int unsigned Z   = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned TD  = 4;
  localparam int unsigned SPR = 3;
  localparam int unsigned DRP = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  irrigation_zone_scheduler_if #(.ZONES(Z), .TIME_WIDTH(TW)) bus ();

  irrigation_zone_scheduler #(
    .ZONES(Z), .TICK_DIV(TD), .TIME_WIDTH(TW),
    .SPRINKLER_SECONDS(SPR), .DRIPPER_SECONDS(DRP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned onehot_bad = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [2:0] probes;  // {high, mid, low}
    logic [2:0] exp;     // {conflicting_values, alarm, water_supply_valvule}
  } vec_t;
  vec_t vt[8];

  always @(negedge clock)
    if (!$onehot0({bus.splinker_bomb, bus.dripper_valvule})) onehot_bad++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired got 0 expected 1", nm);
  endtask

  task automatic sb_check(input string nm, input logic [31:0] act);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d expected none queued", nm, act);
    end else begin
      check(nm, act, sbq.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] valves();
    return {bus.splinker_bomb, bus.dripper_valvule};
  endfunction

  function automatic logic [2:0] flags();
    return {bus.conflicting_values, bus.alarm, bus.water_supply_valvule};
  endfunction

  task automatic set_probes(input logic [2:0] hml);
    bus.high_water_level = hml[2];
    bus.mid_water_level  = hml[1];
    bus.low_water_level  = hml[0];
  endtask

  task automatic wait_valve(input string nm, input int unsigned max, output int unsigned cyc);
    cyc = 0;
    while (valves() == '0 && cyc < max) begin
      step();
      cyc++;
    end
    if (valves() == '0) timeout(nm);
  endtask

  task automatic wait_off(input string nm, input int unsigned max, output int unsigned on);
    on = 1;
    step();
    while (valves() != '0 && on < max) begin
      on++;
      step();
    end
    if (valves() != '0) timeout(nm);
  endtask

  task automatic wait_remaining(input string nm, input logic [TW-1:0] v, input int unsigned max);
    int unsigned c = 0;
    while (bus.remaining_seconds != v && c < max) begin
      step();
      c++;
    end
    if (bus.remaining_seconds != v) timeout(nm);
  endtask

  initial begin
    int unsigned lat, on, cnt_on;
    logic [TW-1:0] prev;
    int unsigned exp_z[4];

    vt[0] = '{probes: 3'b000, exp: 3'b011};
    vt[1] = '{probes: 3'b001, exp: 3'b011};
    vt[2] = '{probes: 3'b010, exp: 3'b110};
    vt[3] = '{probes: 3'b011, exp: 3'b001};
    vt[4] = '{probes: 3'b100, exp: 3'b110};
    vt[5] = '{probes: 3'b101, exp: 3'b110};
    vt[6] = '{probes: 3'b110, exp: 3'b110};
    vt[7] = '{probes: 3'b111, exp: 3'b000};
    exp_z = '{0, 1, 3, 0};

    reset = 1'b1;
    set_probes(3'b000);
    bus.air_humidity    = 1'b0;
    bus.low_temperature = 1'b0;
    bus.zone_dry        = '0;
    bus.skip            = 1'b0;

    // reset state
    step();
    check("rst_valves", valves(), 0);
    check("rst_zone", bus.active_zone, 0);
    check("rst_remaining", bus.remaining_seconds, 0);
    check("rst_conflict", bus.conflicting_values, 0);
    check("rst_alarm", bus.alarm, 1);
    reset = 1'b0;

    // probe decoding, one cycle after the pattern is applied
    for (int unsigned i = 0; i < 8; i++) begin
      set_probes(vt[i].probes);
      sbq.push_back(32'(vt[i].exp));
      step();
      sb_check("flags_table", flags());
    end

    // sprinkler run on zone 1
    set_probes(3'b011);
    step();
    step();
    bus.zone_dry = 4'b0010;
    wait_valve("spr_start", 10, lat);
    check("spr_latency", lat, 3);
    check("spr_mask", bus.splinker_bomb, 4'b0010);
    check("spr_drp", bus.dripper_valvule, 0);
    check("spr_load", bus.remaining_seconds, SPR);
    sbq.push_back(2);
    sbq.push_back(1);
    prev = bus.remaining_seconds;
    on = 1;
    step();
    while (valves() != '0 && on < 40) begin
      if (bus.remaining_seconds != prev) begin
        sb_check("spr_count", bus.remaining_seconds);
        prev = bus.remaining_seconds;
      end
      on++;
      step();
    end
    check("spr_off", valves(), 0);
    check("spr_expired", bus.remaining_seconds, 0);
    check("spr_len_in_range", 32'(on >= (SPR - 1) * TD && on <= SPR * TD), 1);
    check("sb_drained", sbq.size(), 0);
    // next_ptr must now be 2: offer zones 1 and 2, expect 2
    bus.zone_dry = 4'b0110;
    wait_valve("ptr_start", 10, lat);
    check("ptr_latency", lat, 2);
    check("ptr_zone", bus.active_zone, 2);
    check("ptr_mask", bus.splinker_bomb, 4'b0100);
    bus.zone_dry = '0;
    step();
    step();
    check("wet_off", valves(), 0);

    // dripper round-robin from zone 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_probes(3'b111);
    bus.air_humidity = 1'b1;
    bus.zone_dry = 4'b1011;
    for (int unsigned r = 0; r < 4; r++) sbq.push_back(32'(exp_z[r]));
    for (int unsigned r = 0; r < 4; r++) begin
      wait_valve("rr_start", 10, lat);
      sb_check("rr_zone", bus.active_zone);
      check("rr_drp", bus.dripper_valvule, 4'b0001 << exp_z[r]);
      check("rr_spl", bus.splinker_bomb, 0);
      check("rr_load", bus.remaining_seconds, DRP);
      wait_off("rr_end", 40, on);
      check("rr_len_in_range", 32'(on >= (DRP - 1) * TD && on <= DRP * TD), 1);
    end

    // conflict mid-run, then resume at the held pointer
    wait_valve("flt_start", 10, lat);
    check("flt_run_zone", bus.active_zone, 1);
    step();
    step();
    step();
    set_probes(3'b101);
    sbq.push_back(32'(3'b110));
    step();
    sb_check("flt_flags", flags());
    step();
    check("flt_valves", valves(), 0);
    check("flt_remaining", bus.remaining_seconds, 0);
    set_probes(3'b111);
    wait_valve("flt_resume", 10, lat);
    check("flt_resume_latency", lat, 4);
    check("flt_resume_zone", bus.active_zone, 1);
    check("flt_resume_load", bus.remaining_seconds, DRP);

    // low-only tank: dripper mode, then water lost mid-run
    bus.zone_dry = '0;
    step();
    step();
    step();
    check("low_idle", valves(), 0);
    set_probes(3'b001);
    bus.air_humidity = 1'b0;
    sbq.push_back(32'(3'b011));
    step();
    sb_check("low_flags", flags());
    bus.zone_dry = 4'b0100;
    wait_valve("low_start", 10, lat);
    check("low_drp", bus.dripper_valvule, 4'b0100);
    check("low_spl", bus.splinker_bomb, 0);
    step();
    step();
    set_probes(3'b000);
    step();
    check("empty_still_on", bus.dripper_valvule, 4'b0100);
    step();
    check("empty_off", valves(), 0);
    cnt_on = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      if (valves() != '0) cnt_on++;
    end
    check("empty_no_run", cnt_on, 0);

    // skip at count 4, next dry zone two cycles later
    set_probes(3'b111);
    bus.air_humidity = 1'b1;
    bus.zone_dry = 4'b0101;
    wait_valve("skip_start", 10, lat);
    check("skip_zone", bus.active_zone, 0);
    wait_remaining("skip_at4", 4, 20);
    bus.skip = 1'b1;
    step();
    bus.skip = 1'b0;
    step();
    check("skip_off", valves(), 0);
    step();
    check("skip_gap", valves(), 0);
    step();
    check("skip_next_drp", bus.dripper_valvule, 4'b0100);
    check("skip_next_zone", bus.active_zone, 2);

    // reset mid-run at count 2
    wait_remaining("rst_at2", 2, 30);
    reset = 1'b1;
    step();
    check("rstrun_valves", valves(), 0);
    check("rstrun_zone", bus.active_zone, 0);
    check("rstrun_remaining", bus.remaining_seconds, 0);
    reset = 1'b0;
    wait_valve("rstrun_restart", 10, lat);
    check("rstrun_latency", lat, 3);
    check("rstrun_next_zone", bus.active_zone, 0);

    check("valve_onehot", onehot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
